// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller.
//   - controller FSM state encoding (RUN / MDU_WAIT)
//   - forward-select codes driven on fwd_a / fwd_b
//   - fwd_sel(): priority forward mux select (EX result over MEM result)
package pipe_pkg;

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MDU_WAIT = 1'b1;

   localparam logic [1:0] FWD_REG = 2'd0;  // operand from register file
   localparam logic [1:0] FWD_MEM = 2'd1;  // EX result, now in MEM
   localparam logic [1:0] FWD_WB  = 2'd2;  // MEM result, now in WB

   typedef logic [1:0] fwd_t;

   // The younger producer (EX) must win, it holds the newest value.
   function automatic fwd_t fwd_sel(input logic ex_hit, input logic ex_wen,
                                    input logic mem_hit, input logic mem_wen);
      if (ex_hit && ex_wen)
         return FWD_MEM;
      else if (mem_hit && mem_wen)
         return FWD_WB;
      else
         return FWD_REG;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/forward bus between the pipeline datapath and pipe_ctrl.
//   Datapath -> controller: ID sources and use flags, id_mdu, EX/MEM
//     destinations and write/load flags, ex_branch_taken, ex_mdu_start.
//   Controller -> datapath: pc_en, if_id_en, if_id_flush, id_ex_flush,
//     fwd_a, fwd_b, mdu_busy.
// master = datapath side, slave = controller side.
interface pipe_ctrl_if #(parameter int RW = 5);
   logic [RW-1:0] id_rs, id_rt;
   logic          id_use_rs, id_use_rt;
   logic          id_mdu;
   logic [RW-1:0] ex_rd, mem_rd;
   logic          ex_regwrite, mem_regwrite, ex_memtoreg;
   logic          ex_branch_taken;
   logic          ex_mdu_start;
   logic          pc_en, if_id_en, if_id_flush, id_ex_flush;
   logic [1:0]    fwd_a, fwd_b;
   logic          mdu_busy;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_mdu, ex_rd, mem_rd,
             ex_regwrite, mem_regwrite, ex_memtoreg, ex_branch_taken, ex_mdu_start,
      input  pc_en, if_id_en, if_id_flush, id_ex_flush, fwd_a, fwd_b, mdu_busy
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_mdu, ex_rd, mem_rd,
             ex_regwrite, mem_regwrite, ex_memtoreg, ex_branch_taken, ex_mdu_start,
      output pc_en, if_id_en, if_id_flush, id_ex_flush, fwd_a, fwd_b, mdu_busy
   );
endinterface

// File: rtl/pipe_hazard_cmp.sv
// Source/destination register comparator (combinational).
//   src     : ID source register specifier
//   use_src : ID instruction actually reads src
//   dst     : downstream destination register specifier
//   hit     : src is read and matches a non-zero dst
// Register 0 is hard-wired zero, so it never produces a hazard.
module pipe_hazard_cmp #(
   parameter int RW = 5
) (
   input  logic [RW-1:0] src,
   input  logic          use_src,
   input  logic [RW-1:0] dst,
   output logic          hit
);
   assign hit = use_src && (dst != '0) && (src == dst);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / forwarding controller.
//   clk, rst (async, active-high) plus the pipe_ctrl_if slave bus.
//   Produces PC / IF-ID enables, flushes, operand forward selects and
//   the multiply/divide busy flag. All outputs are combinational.
// Parameters: MDU_CYCLES (2..255) MDU latency, RW register-specifier width.
// Build option: define PIPE_CTRL_FORWARD_EN to enable EX/MEM forwarding;
//   otherwise fwd_a/fwd_b stay 0 and any RAW match on EX/MEM stalls.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MDU_CYCLES = 32,
   parameter int RW         = 5
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);

   localparam logic [7:0] CNT_LOAD = 8'(MDU_CYCLES - 1);

   // index 0 = rs, 1 = rt ; destination 0 = EX, 1 = MEM
   logic [1:0][RW-1:0] src;
   logic [1:0]         use_src;
   logic [1:0][RW-1:0] dst;
   logic [1:0][1:0]    hit;   // hit[src][dst]

   assign src     = {bus.id_rt, bus.id_rs};
   assign use_src = {bus.id_use_rt, bus.id_use_rs};
   assign dst     = {bus.mem_rd, bus.ex_rd};

   for (genvar s = 0; s < 2; s++) begin : g_src
      for (genvar d = 0; d < 2; d++) begin : g_dst
         pipe_hazard_cmp #(.RW(RW)) u_cmp (
            .src     (src[s]),
            .use_src (use_src[s]),
            .dst     (dst[d]),
            .hit     (hit[s][d])
         );
      end
   end

   // MDU wait FSM
   logic [0:0] state;
   logic [7:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         case (state)
            ST_RUN: if (bus.ex_mdu_start) begin
               state <= ST_MDU_WAIT;
               cnt   <= CNT_LOAD;
            end
            default: begin
               // a new MDU start cannot be issued here: ID is held by mdu_stall
               if (cnt == '0) state <= ST_RUN;
               else           cnt   <= cnt - 8'd1;
            end
         endcase
      end
   end

   logic mdu_stall, lu_stall, raw_stall, stall;
   logic ex_hit, mem_hit;
   fwd_t fwd_a_n, fwd_b_n;

   assign ex_hit    = hit[0][0] | hit[1][0];
   assign mem_hit   = hit[0][1] | hit[1][1];
   assign mdu_stall = (state == ST_MDU_WAIT) && bus.id_mdu;
   assign lu_stall  = bus.ex_memtoreg && ex_hit;

`ifdef PIPE_CTRL_FORWARD_EN
   assign fwd_a_n   = fwd_sel(hit[0][0], bus.ex_regwrite, hit[0][1], bus.mem_regwrite);
   assign fwd_b_n   = fwd_sel(hit[1][0], bus.ex_regwrite, hit[1][1], bus.mem_regwrite);
   assign raw_stall = 1'b0;
`else
   // No bypass: wait until the producer reaches WB (regfile writes before reads).
   assign fwd_a_n   = FWD_REG;
   assign fwd_b_n   = FWD_REG;
   assign raw_stall = (bus.ex_regwrite && ex_hit) || (bus.mem_regwrite && mem_hit);
`endif

   assign stall = lu_stall | mdu_stall | raw_stall;

   always_comb begin
      bus.pc_en       = 1'b1;
      bus.if_id_en    = 1'b1;
      bus.if_id_flush = 1'b0;
      bus.id_ex_flush = 1'b0;
      bus.fwd_a       = fwd_a_n;
      bus.fwd_b       = fwd_b_n;
      bus.mdu_busy    = (state == ST_MDU_WAIT);
      if (rst) begin
         bus.pc_en       = 1'b0;
         bus.if_id_en    = 1'b0;
         bus.if_id_flush = 1'b1;
         bus.id_ex_flush = 1'b1;
         bus.fwd_a       = FWD_REG;
         bus.fwd_b       = FWD_REG;
         bus.mdu_busy    = 1'b0;
      end else if (bus.ex_branch_taken) begin
         // wrong-path instructions are discarded, so a stall is moot
         bus.if_id_flush = 1'b1;
         bus.id_ex_flush = 1'b1;
      end else if (stall) begin
         bus.pc_en       = 1'b0;
         bus.if_id_en    = 1'b0;
         bus.id_ex_flush = 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MDU_CYCLES=4, RW=5).
// Expectations for forwarding follow PIPE_CTRL_FORWARD_EN.
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   pipe_ctrl_if #(.RW(5)) bus ();

   pipe_ctrl #(.MDU_CYCLES(4), .RW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // pc_en, if_id_en, if_id_flush, id_ex_flush as one nibble
   function automatic logic [7:0] ctl();
      return {4'b0, bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush};
   endfunction

   task automatic clr();
      bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
      bus.id_mdu = 0; bus.ex_rd = '0; bus.mem_rd = '0;
      bus.ex_regwrite = 0; bus.mem_regwrite = 0; bus.ex_memtoreg = 0;
      bus.ex_branch_taken = 0; bus.ex_mdu_start = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   localparam logic [7:0] RUN_CTL   = 8'b1100;
   localparam logic [7:0] STALL_CTL = 8'b0001;
   localparam logic [7:0] FLUSH_CTL = 8'b1111;
   localparam logic [7:0] RST_CTL   = 8'b0011;

   initial begin
      clr();
      // reset, with an EX->ID match present that forwarding would otherwise select
      bus.ex_rd = 5'd9; bus.ex_regwrite = 1; bus.id_rt = 5'd9; bus.id_use_rt = 1;
      #1;
      chk("rst_ctl", ctl(), RST_CTL);
      chk("rst_fwd_b", {6'b0, bus.fwd_b}, 8'd0);
      chk("rst_busy", {7'b0, bus.mdu_busy}, 8'd0);
      tick(); tick();
      rst = 0; clr(); #1;
      chk("idle_ctl", ctl(), RUN_CTL);

      // load-use: lw $8 in EX, ID reads rs=8
      tick();
      bus.ex_memtoreg = 1; bus.ex_regwrite = 1; bus.ex_rd = 5'd8;
      bus.id_rs = 5'd8; bus.id_use_rs = 1; #1;
      chk("lu_stall", ctl(), STALL_CTL);
      tick(); clr(); bus.id_rs = 5'd8; bus.id_use_rs = 1; #1;
      chk("lu_after", ctl(), RUN_CTL);
      // load to $0 never stalls
      bus.ex_memtoreg = 1; bus.ex_regwrite = 1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; #1;
      chk("lu_r0", ctl(), RUN_CTL);
      // rt matches but is not read
      clr(); bus.ex_memtoreg = 1; bus.ex_rd = 5'd7; bus.id_rt = 5'd7; bus.id_use_rt = 0; #1;
      chk("lu_unused_rt", ctl(), RUN_CTL);
      bus.id_use_rt = 1; #1;
      chk("lu_rt", ctl(), STALL_CTL);
      // load-use and taken branch together: flush wins
      bus.ex_branch_taken = 1; #1;
      chk("lu_branch", ctl(), FLUSH_CTL);

      // forwarding on rt
      clr(); tick();
      bus.ex_rd = 5'd9; bus.mem_rd = 5'd9; bus.ex_regwrite = 1; bus.mem_regwrite = 1;
      bus.id_rt = 5'd9; bus.id_use_rt = 1; #1;
`ifdef PIPE_CTRL_FORWARD_EN
      chk("fwd_b_ex", {6'b0, bus.fwd_b}, 8'd1);
      chk("fwd_ex_ctl", ctl(), RUN_CTL);
      bus.ex_regwrite = 0; #1;
      chk("fwd_b_mem", {6'b0, bus.fwd_b}, 8'd2);
      chk("fwd_a_idle", {6'b0, bus.fwd_a}, 8'd0);
`else
      chk("nofwd_b_ex", {6'b0, bus.fwd_b}, 8'd0);
      chk("nofwd_ex_ctl", ctl(), STALL_CTL);
      bus.ex_regwrite = 0; #1;
      chk("nofwd_b_mem", {6'b0, bus.fwd_b}, 8'd0);
      chk("nofwd_mem_ctl", ctl(), STALL_CTL);
`endif
      bus.ex_regwrite = 1; bus.ex_rd = 5'd0; bus.mem_rd = 5'd0; bus.id_rt = 5'd0; #1;
      chk("fwd_b_r0", {6'b0, bus.fwd_b}, 8'd0);
      chk("fwd_r0_ctl", ctl(), RUN_CTL);

      // MEM producer on rs
      clr(); bus.mem_rd = 5'd5; bus.mem_regwrite = 1; bus.id_rs = 5'd5; bus.id_use_rs = 1; #1;
`ifdef PIPE_CTRL_FORWARD_EN
      chk("mem_rs_fwd_a", {6'b0, bus.fwd_a}, 8'd2);
      chk("mem_rs_ctl", ctl(), RUN_CTL);
`else
      chk("mem_rs_fwd_a", {6'b0, bus.fwd_a}, 8'd0);
      chk("mem_rs_ctl", ctl(), STALL_CTL);
`endif
      tick(); clr(); bus.id_rs = 5'd5; bus.id_use_rs = 1; #1;
      chk("mem_rs_after", ctl(), RUN_CTL);

      // MDU: start issued, then id_mdu held; busy for exactly 4 cycles
      clr(); bus.ex_mdu_start = 1; #1;
      chk("mdu_start_busy", {7'b0, bus.mdu_busy}, 8'd0);
      chk("mdu_start_ctl", ctl(), RUN_CTL);
      tick(); bus.ex_mdu_start = 0; bus.id_mdu = 1;
      for (int i = 0; i < 4; i++) begin
         bus.ex_mdu_start = (i == 1);   // must not reload the counter
         #1;
         chk($sformatf("mdu_busy_%0d", i), {7'b0, bus.mdu_busy}, 8'd1);
         chk($sformatf("mdu_stall_%0d", i), ctl(), STALL_CTL);
         tick();
      end
      bus.ex_mdu_start = 0; #1;
      chk("mdu_rel_busy", {7'b0, bus.mdu_busy}, 8'd0);
      chk("mdu_rel_ctl", ctl(), RUN_CTL);

      // busy but ID not an MDU op: no stall
      clr(); bus.ex_mdu_start = 1; tick(); bus.ex_mdu_start = 0; #1;
      chk("mdu_nouse_busy", {7'b0, bus.mdu_busy}, 8'd1);
      chk("mdu_nouse_ctl", ctl(), RUN_CTL);
      // wait out this op (cnt 3 now; 4 WAIT cycles total)
      tick(); tick(); tick(); tick(); #1;
      chk("mdu_nouse_done", {7'b0, bus.mdu_busy}, 8'd0);

      // reset in the middle of a wait (cnt=2)
      bus.ex_mdu_start = 1; tick(); bus.ex_mdu_start = 0; bus.id_mdu = 1;
      tick();   // cnt now 2
      rst = 1; #1;
      chk("mdu_rst_ctl", ctl(), RST_CTL);
      chk("mdu_rst_busy", {7'b0, bus.mdu_busy}, 8'd0);
      tick();
      rst = 0; #1;
      chk("post_rst_busy", {7'b0, bus.mdu_busy}, 8'd0);
      chk("post_rst_ctl", ctl(), RUN_CTL);
      tick(); #1;
      chk("post_rst_busy2", {7'b0, bus.mdu_busy}, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter MDU_CYCLES, default 32, meaning multiply/divide latency in cycles (legal range 2..255).
REQ-002 SHALL provide parameter RW, default 5, meaning register-specifier width.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports id_rs, id_rt  in  RW  source registers of the instruction in ID.
REQ-006 SHALL have ports id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt.
REQ-007 SHALL have port id_mdu  in  1  ID instruction is an MDU op or reads HI/LO.
REQ-008 SHALL have ports ex_rd, mem_rd  in  RW  destination registers in EX and MEM.
REQ-009 SHALL have ports ex_regwrite, mem_regwrite, ex_memtoreg  in  1  write-enable and load flags.
REQ-010 SHALL have ports ex_branch_taken  in  1  and ex_mdu_start  in  1  (resolved branch/jump; MDU op issued from EX).
REQ-011 SHALL have ports pc_en, if_id_en, if_id_flush, id_ex_flush  out  1  pipeline-register controls.
REQ-012 SHALL have ports fwd_a, fwd_b  out  2  operand forward select (0 regfile, 1 from MEM, 2 from WB); and mdu_busy  out  1.

Function
REQ-013 SHALL implement FSM states RUN and MDU_WAIT plus an 8-bit down-counter cnt.
REQ-014 SHALL, in RUN with ex_mdu_start=1, load cnt=MDU_CYCLES-1 and enter MDU_WAIT next cycle.
REQ-015 SHALL, in MDU_WAIT, decrement cnt each cycle and return to RUN in the cycle after cnt reaches 0.
REQ-016 SHALL drive mdu_busy=1 exactly while state is MDU_WAIT.
REQ-017 SHALL ignore ex_mdu_start while in MDU_WAIT (cannot occur; REQ-018 prevents it).
REQ-018 SHALL raise mdu_stall when state=MDU_WAIT and id_mdu=1.
REQ-019 SHALL raise lu_stall when ex_memtoreg=1, ex_rd!=0 and ex_rd equals a used ID source (id_rs with id_use_rs, or id_rt with id_use_rt).
REQ-020 SHALL, with stall=(lu_stall|mdu_stall) and no branch, drive pc_en=0, if_id_en=0, id_ex_flush=1; otherwise pc_en=1, if_id_en=1.
REQ-021 SHALL, when ex_branch_taken=1, drive if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_en=1 regardless of any stall (flush beats stall).
REQ-022 SHALL compute all outputs combinationally from inputs and state (zero-cycle latency).
REQ-023 SHALL never match register 0 for any hazard or forward.

Reset
REQ-024 SHALL, while rst=1, force state=RUN, cnt=0, mdu_busy=0, pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, fwd_a=fwd_b=0.
REQ-025 SHALL abandon an in-progress MDU wait on rst; first cycle after release is RUN with no stall.

Configuration
REQ-026 SHALL honour macro PIPE_CTRL_FORWARD_EN.
REQ-027 SHALL, when defined, set fwd_x=1 if ex_regwrite & ex_rd==src (EX result, now in MEM), else 2 if mem_regwrite & mem_rd==src, else 0; EX priority over MEM.
REQ-028 SHALL, when undefined, tie fwd_a=fwd_b=0 and additionally stall (REQ-020) on any used-source match with ex_rd (ex_regwrite) or mem_rd (mem_regwrite); regfile writes before reads.

Structure
REQ-029 SHALL place state encoding (RUN/MDU_WAIT) and FWD_REG/FWD_MEM/FWD_WB select constants in shared package pipe_pkg.
REQ-030 SHALL use one sub-module, pipe_hazard_cmp: combinational source/destination comparator instantiated per (src,dst) pair.

Verification
REQ-031 SHALL cover: lw $8 in EX (ex_memtoreg=1, ex_rd=8), ID reads rs=8 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1, then no stall.
REQ-032 SHALL cover (FORWARD_EN): ex_rd=9 and mem_rd=9 both writing, id_rt=9 -> fwd_b=1; ex_regwrite=0 -> fwd_b=2; rd=0 -> fwd_b=0.
REQ-033 SHALL cover: ex_mdu_start with MDU_CYCLES=4, id_mdu=1 held -> mdu_busy high exactly 4 cycles, stall for those 4, release in 5th.
REQ-034 SHALL cover: load-use stall and ex_branch_taken same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1.
REQ-035 SHALL cover: rst asserted at cnt=2 in MDU_WAIT -> immediate REQ-024 values; after release mdu_busy=0, pc_en=1.
REQ-036 SHALL cover (no FORWARD_EN): mem_rd=5 writing, id_rs=5 used -> stall one cycle, fwd_a=0.
